// File: rtl/key_freq_pkg.sv
// Shared constants for the front-panel key / frequency setpoint block.
package key_freq_pkg;

    // Waveform selection encoding driven on wave_sel
    localparam logic [1:0] WAVE_SINE   = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_TRI    = 2'd2;
    localparam logic [1:0] WAVE_SAW    = 2'd3;

    // Setpoint limits in BCD
    localparam logic [15:0] FREQ_MAX = 16'h9999;
    localparam logic [15:0] FREQ_MIN = 16'h0001;

    // Button indices into the press vector; lower index wins on a tie
    localparam int NUM_BTN  = 4;
    localparam int BTN_INC  = 0;   // aaa
    localparam int BTN_DEC  = 1;   // bbb
    localparam int BTN_CUR  = 2;   // ccc
    localparam int BTN_WAVE = 3;   // ddd

    // Press command after priority resolution
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_INC,
        CMD_DEC,
        CMD_CUR,
        CMD_WAVE
    } cmd_e;

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, stable-level debouncer and
// rising-edge detector producing a single-cycle registered press pulse.
module key_debounce
    import key_freq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Two-flop synchronizer for the asynchronous raw button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing clocks; flip the level once the
    // disagreement has lasted DEBOUNCE_CYCLES clocks, clear on agreement
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debouncer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered rising-edge pulse of the accepted level; release is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            prev_q  <= level_q;
            press_q <= level_q & ~prev_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/key_freq_ctrl.sv
// Front-panel control: four debounced buttons edit a 4-digit BCD frequency
// setpoint, an edit cursor and a waveform selection. All outputs registered.
module key_freq_ctrl
    import key_freq_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter logic [15:0] FREQ_RESET      = 16'h0999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        aaa,
    input  logic        bbb,
    input  logic        ccc,
    input  logic        ddd,
    output logic [15:0] freq_bcd,
    output logic [1:0]  cursor,
    output logic [1:0]  wave_sel,
    output logic        upd
);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] press;

    cmd_e        cmd;
    logic [15:0] freq_q, freq_d;
    logic [1:0]  cur_q, cur_d;
    logic [1:0]  wave_q, wave_d;
    logic        upd_q, upd_d;

    // Add 10^pos with decimal carry; an overflow past the top digit clamps
    function automatic logic [15:0] bcd_inc(input logic [15:0] f, input logic [1:0] pos);
        logic [15:0] r;
        logic        c;
        logic [4:0]  s;
        logic [4:0]  t;
        r = f;
        c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s = {1'b0, f[i*4 +: 4]} + {4'd0, (i == int'(pos))} + {4'd0, c};
            if (s > 5'd9) begin
                t          = s - 5'd10;
                r[i*4 +: 4] = t[3:0];
                c          = 1'b1;
            end else begin
                r[i*4 +: 4] = s[3:0];
                c          = 1'b0;
            end
        end
        if (c) r = FREQ_MAX;
        return r;
    endfunction

    // Subtract 10^pos with decimal borrow; underflow or zero clamps to 0001
    function automatic logic [15:0] bcd_dec(input logic [15:0] f, input logic [1:0] pos);
        logic [15:0] r;
        logic        b;
        logic [4:0]  d;
        logic [4:0]  m;
        logic [4:0]  t;
        r = f;
        b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, f[i*4 +: 4]};
            m = {4'd0, (i == int'(pos))} + {4'd0, b};
            if (d < m) begin
                t          = d + 5'd10 - m;
                r[i*4 +: 4] = t[3:0];
                b          = 1'b1;
            end else begin
                t          = d - m;
                r[i*4 +: 4] = t[3:0];
                b          = 1'b0;
            end
        end
        if (b || (r == 16'h0000)) r = FREQ_MIN;
        return r;
    endfunction

    assign raw[BTN_INC]  = aaa;
    assign raw[BTN_DEC]  = bbb;
    assign raw[BTN_CUR]  = ccc;
    assign raw[BTN_WAVE] = ddd;

    // Each button debounces on its own so one press never stalls another
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_i   (raw[g]),
            .press_o (press[g])
        );
    end

    // Fixed-priority pick of one press per cycle; the rest are dropped
    always_comb begin
        cmd = CMD_NONE;
        if (press[BTN_INC])       cmd = CMD_INC;
        else if (press[BTN_DEC])  cmd = CMD_DEC;
        else if (press[BTN_CUR])  cmd = CMD_CUR;
        else if (press[BTN_WAVE]) cmd = CMD_WAVE;
    end

    // Apply the winning command; upd only flags a real change
    always_comb begin
        freq_d = freq_q;
        cur_d  = cur_q;
        wave_d = wave_q;
        case (cmd)
            CMD_INC:  freq_d = bcd_inc(freq_q, cur_q);
            CMD_DEC:  freq_d = bcd_dec(freq_q, cur_q);
            CMD_CUR:  cur_d  = cur_q + 2'd1;
            CMD_WAVE: wave_d = wave_q + 2'd1;
            default:  ;
        endcase
        upd_d = (freq_d != freq_q) || (cur_d != cur_q) || (wave_d != wave_q);
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_q <= FREQ_RESET;
            cur_q  <= 2'd0;
            wave_q <= WAVE_SINE;
            upd_q  <= 1'b0;
        end else begin
            freq_q <= freq_d;
            cur_q  <= cur_d;
            wave_q <= wave_d;
            upd_q  <= upd_d;
        end
    end

    assign freq_bcd = freq_q;
    assign cursor   = cur_q;
    assign wave_sel = wave_q;
    assign upd      = upd_q;

endmodule

// File: doc/key_freq_ctrl.md
# key_freq_ctrl

Front-panel control stage of the signal generator: debounces the four push-buttons (aaa, bbb, ccc, ddd) and turns presses into an edited 4-digit BCD frequency setpoint, an edit cursor and a waveform selection. Sits directly upstream of the display/scan driver (seg/an/dp) and the waveform synthesis core, both of which consume its registered outputs. Runs on the 50 MHz board clock.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable clocks required before a button level is accepted (5 ms at 50 MHz); benches use 4
- FREQ_RESET, 16'h0999, BCD setpoint loaded at reset (999 Hz)

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset; one clock domain
- aaa  in  1  raw button, active-high: increment
- bbb  in  1  raw button, active-high: decrement
- ccc  in  1  raw button, active-high: move cursor
- ddd  in  1  raw button, active-high: next waveform
- freq_bcd  out  16  setpoint, 4 BCD digits, [3:0] = units
- cursor  out  2  selected digit, 0 = units … 3 = thousands
- wave_sel  out  2  0 sine, 1 square, 2 triangle, 3 sawtooth
- upd  out  1  one-cycle pulse the cycle any output above changes

## Operation
- Per button: 2-flop synchronizer -> debouncer -> rising-edge detector giving one-cycle press pulse.
- Debouncer: counter runs while synchronized input differs from accepted level; clears on any agreement; when mismatch has persisted DEBOUNCE_CYCLES clocks, level flips, counter clears. Glitches shorter than DEBOUNCE_CYCLES never flip the level.
- Only the press (0->1) of the accepted level generates an event; release generates nothing; no auto-repeat while held.
- aaa: freq_bcd += 10^cursor, BCD carry across digits, saturates at 9999.
- bbb: freq_bcd -= 10^cursor, BCD borrow; if result < 1 (incl. underflow) setpoint becomes 0001.
- ccc: cursor = cursor + 1, wraps 3 -> 0.
- ddd: wave_sel = wave_sel + 1, wraps 3 -> 0.
- Simultaneous press pulses in one cycle: priority aaa > bbb > ccc > ddd; only the winner is applied, others discarded.
- upd asserted only if a value actually changed (saturated inc at 9999, or dec at 0001, gives no upd).
- freq_bcd digits are always valid BCD (0–9).

## Timing
- Reset (async assert, sync-safe deassert): freq_bcd = FREQ_RESET, cursor = 0, wave_sel = 0, upd = 0, all synchronizers, accepted levels and counters = 0.
- Latency: raw edge -> synchronized after 2 clocks -> accepted level flips DEBOUNCE_CYCLES clocks later -> press pulse registered next clock -> outputs and upd updated on the following clock. Total 2 + DEBOUNCE_CYCLES + 2 clocks, fixed.
- All outputs registered; upd high exactly one clock, coincident with the new output values.
- Reset mid-debounce: count lost; a button held through reset release is debounced afresh and produces one press.
- Separate buttons debounce independently; a press on one never delays another.

## Structure
- Package key_freq_pkg: wave encoding constants (WAVE_SINE, WAVE_SQUARE, WAVE_TRI, WAVE_SAW), FREQ_MAX 16'h9999, FREQ_MIN 16'h0001, button index constants.
- Sub-module key_debounce (sync + debounce + edge detect, parameter DEBOUNCE_CYCLES), instantiated four times; BCD add/sub and priority logic in key_freq_ctrl.

## Test plan
- Reset, no presses -> freq_bcd 0999, cursor 0, wave_sel 0, upd never high.
- DEBOUNCE_CYCLES=4: aaa high 3 clocks, low -> no change; aaa high 20 clocks -> freq_bcd 1000, upd one clock exactly 8 clocks after raw rise.
- ccc pressed twice (cursor 2), aaa on 9950 -> 9999 saturated, upd only if changed; bbb at cursor 3 on 0999 -> 0001.
- ccc pressed 5 times -> cursor 1; ddd pressed 5 times -> wave_sel 1.
- aaa and ccc raised same clock -> freq_bcd +10^cursor, cursor unchanged; holding aaa 1000 clocks -> single increment.
- rst_n pulled low mid-debounce with bbb held -> outputs reset immediately; after release bbb produces one decrement.
